axi_lite_stream_adder: RTL and testbench

Register-slave and datapath end of the AXI4-Lite/AXI4-Stream example pipeline. An AXI4-Lite slave exposes ID, VER, STATS and COEF registers. A 16-bit AXI4-Stream pipeline adds COEF to every input sample and forwards the result. The block sits between the AXI4-Lite master VIP and the stream master/slave VIPs in the block design.

---
 rtl/axi_lite_stream_adder.sv | 195 +++++++++++++++++++
 tb/tb_axi_lite_stream_adder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_stream_adder.sv
// axi_lite_stream_adder: AXI4-Lite register slave (ID/VER/STATS/COEF) plus a one-stage stream adder that offsets every sample by COEF
module axi_lite_stream_adder #(
   parameter logic [31:0] ID_VALUE  = 32'hA1F0_0003,
   parameter logic [31:0] VER_VALUE = 32'h0001_0000,
   parameter int          ADDR_W    = 8,
   parameter int          DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   input  logic [DATA_W-1:0] in_tdata,
   input  logic              in_tvalid,
   output logic              in_tready,
   output logic [DATA_W-1:0] out_tdata,
   output logic              out_tvalid,
   input  logic              out_tready
);
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_SLVERR = 2'b10;
   localparam logic [ADDR_W-1:0] A_ID        = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_VER       = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_STATS     = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_COEF      = ADDR_W'(8'h0C);

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [1:0]        wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [15:0]       coef_q, coef_d;
   logic [31:0]       stats_q, stats_d;
   logic              out_tvalid_q, out_tvalid_d;
   logic [DATA_W-1:0] out_tdata_q, out_tdata_d;
   logic              aw_hs, w_hs, ar_hs, in_hs, out_hs, wr_fire;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic [1:0]        wr_strb;
   logic [31:0]       rd_val;
   logic              unused_bits;

   function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
      return a == A_ID || a == A_VER || a == A_STATS || a == A_COEF;
   endfunction

   // only the low COEF bytes are writable, so the upper write lanes are ignored
   assign unused_bits   = ^{s_axi_wdata[31:16], s_axi_wstrb[3:2]};

   assign s_axi_awready = wr_state_q == W_IDLE && !aw_full_q;
   assign s_axi_wready  = wr_state_q == W_IDLE && !w_full_q;
   assign s_axi_bvalid  = wr_state_q == W_RESP;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = rd_state_q == R_IDLE;
   assign s_axi_rvalid  = rd_state_q == R_DATA;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // a write commits in the cycle the second of AW/W arrives, using whichever half is already latched
   assign wr_addr = aw_full_q ? awaddr_q : s_axi_awaddr;
   assign wr_data = w_full_q ? wdata_q : s_axi_wdata[15:0];
   assign wr_strb = w_full_q ? wstrb_q : s_axi_wstrb[1:0];
   assign wr_fire = wr_state_q == W_IDLE && (aw_full_q || aw_hs) && (w_full_q || w_hs);

   assign rd_val = s_axi_araddr == A_ID    ? ID_VALUE :
                   s_axi_araddr == A_VER   ? VER_VALUE :
                   s_axi_araddr == A_STATS ? stats_q :
                   s_axi_araddr == A_COEF  ? {16'h0000, coef_q} : 32'hDEAD_BEEF;

   assign in_tready  = !out_tvalid_q || out_tready;
   assign in_hs      = in_tvalid && in_tready;
   assign out_hs     = out_tvalid_q && out_tready;
   assign out_tvalid = out_tvalid_q;
   assign out_tdata  = out_tdata_q;

   // write FSM: latch AW and W independently, commit once both are present, hold B until bready
   always_comb begin
      wr_state_d = wr_state_q;
      aw_full_d  = aw_full_q;
      w_full_d   = w_full_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      if (aw_hs) begin
         aw_full_d = 1'b1;
         awaddr_d  = s_axi_awaddr;
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s_axi_wdata[15:0];
         wstrb_d  = s_axi_wstrb[1:0];
      end
      if (wr_fire) begin
         wr_state_d = W_RESP;
         bresp_d    = is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      end else if (wr_state_q == W_RESP && s_axi_bready) begin
         wr_state_d = W_IDLE;
         aw_full_d  = 1'b0;
         w_full_d   = 1'b0;
      end
   end

   // read FSM: capture data and response on AR, hold them until rready
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      if (ar_hs) begin
         rd_state_d = R_DATA;
         rdata_d    = rd_val;
         rresp_d    = is_mapped(s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
      end else if (rd_state_q == R_DATA && s_axi_rready) begin
         rd_state_d = R_IDLE;
      end
   end

   // register file and stream stage next-state; a STATS write beats a same-cycle output handshake
   always_comb begin
      coef_d = coef_q;
      if (wr_fire && wr_addr == A_COEF) begin
         coef_d[7:0]  = wr_strb[0] ? wr_data[7:0] : coef_q[7:0];
         coef_d[15:8] = wr_strb[1] ? wr_data[15:8] : coef_q[15:8];
      end
      stats_d      = (wr_fire && wr_addr == A_STATS) ? 32'h0 : stats_q + 32'(out_hs);
      out_tvalid_d = in_hs ? 1'b1 : out_hs ? 1'b0 : out_tvalid_q;
      out_tdata_d  = in_hs ? in_tdata + DATA_W'(coef_q) : out_tdata_q;
   end

   // AXI4-Lite channel state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= W_IDLE;
         aw_full_q  <= 1'b0;
         w_full_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_full_q  <= aw_full_d;
         w_full_q   <= w_full_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   // COEF, STATS and the stream output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q       <= '0;
         stats_q      <= '0;
         out_tvalid_q <= 1'b0;
         out_tdata_q  <= '0;
      end else begin
         coef_q       <= coef_d;
         stats_q      <= stats_d;
         out_tvalid_q <= out_tvalid_d;
         out_tdata_q  <= out_tdata_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_stream_adder.sv
// tb_axi_lite_stream_adder: directed and randomized checks of the register slave and stream adder against a queue-based model
module tb_axi_lite_stream_adder;
   localparam logic [31:0] ID_V  = 32'hA1F0_0003;
   localparam logic [31:0] VER_V = 32'h0001_0000;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic [7:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
   logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
   logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic [31:0] s_axi_rdata;
   logic [15:0] in_tdata = '0, out_tdata;
   logic        in_tvalid = 1'b0, in_tready, out_tvalid, out_tready = 1'b1;

   always #5 clk = ~clk;

   axi_lite_stream_adder dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready)
   );

   int          n_cmp = 0, n_bad = 0;
   logic [15:0] src_q[$], exp_q[$];
   logic [15:0] coef_m = '0, coef_new = '0, prev_data = '0;
   logic [31:0] stats_m = '0;
   bit          clr_stats, coef_wr, st_in_hs, st_out_hs, prev_stall, rand_in;
   int          rdy_mode = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit mapped(input logic [7:0] a);
      return a inside {8'h00, 8'h04, 8'h08, 8'h0C};
   endfunction

   function automatic logic [31:0] reg_model(input logic [7:0] a);
      case (a)
         8'h00:   return ID_V;
         8'h04:   return VER_V;
         8'h08:   return stats_m;
         8'h0C:   return {16'h0000, coef_m};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // one clock: apply model effects of the edge, drive the stream after it, observe at the falling edge
   task automatic tick();
      logic [15:0] e;
      @(posedge clk);
      if (st_in_hs) begin
         exp_q.push_back(16'(src_q[0] + coef_m));
         src_q.delete(0);
      end
      if (clr_stats) stats_m = '0;
      else if (st_out_hs) stats_m = stats_m + 1;
      if (coef_wr) coef_m = coef_new;
      clr_stats = 0;
      coef_wr   = 0;
      #1;
      if (!(in_tvalid && !st_in_hs)) begin
         in_tvalid = src_q.size() > 0 && (!rand_in || $urandom_range(0, 3) != 0);
         in_tdata  = src_q.size() > 0 ? src_q[0] : 16'h0;
      end
      out_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_tready : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      st_in_hs  = in_tvalid && in_tready;
      st_out_hs = out_tvalid && out_tready;
      chk("in_tready", 32'(in_tready), 32'(!out_tvalid || out_tready));
      if (prev_stall) chk("stall_hold", 32'({out_tvalid, out_tdata}), 32'({1'b1, prev_data}));
      if (st_out_hs) begin
         e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
         chk("out_tdata", 32'(out_tdata), 32'(e));
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
   endtask

   // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
   task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, input int bdly);
      int       n, aw_at, w_at;
      bit       aw_done, w_done, aw_hs, w_hs;
      logic [1:0] er;
      aw_at = lead < 0 ? -lead : 0;
      w_at  = lead > 0 ? lead : 0;
      er    = mapped(a) ? 2'b00 : 2'b10;
      aw_done = 0;
      w_done  = 0;
      n       = 0;
      s_axi_awaddr = a;
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      while (!(aw_done && w_done)) begin
         if (n > 20) begin
            chk("wr_accept", 32'({aw_done, w_done}), 32'b11);
            break;
         end
         s_axi_awvalid = !aw_done && n >= aw_at;
         s_axi_wvalid  = !w_done && n >= w_at;
         chk("awready", 32'(s_axi_awready), 32'(!aw_done));
         chk("wready", 32'(s_axi_wready), 32'(!w_done));
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            if (a == 8'h08) clr_stats = 1;
            if (a == 8'h0C) begin
               coef_new = {s[1] ? d[15:8] : coef_m[15:8], s[0] ? d[7:0] : coef_m[7:0]};
               coef_wr  = 1;
            end
         end
         tick();
         aw_done = aw_done || aw_hs;
         w_done  = w_done || w_hs;
         n++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      for (int i = 0; i < bdly; i++) begin
         chk("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
         chk("bresp_hold", 32'(s_axi_bresp), 32'(er));
         tick();
      end
      s_axi_bready = 1'b1;
      chk("bvalid", 32'(s_axi_bvalid), 32'd1);
      chk($sformatf("bresp@%h", a), 32'(s_axi_bresp), 32'(er));
      tick();
      s_axi_bready = 1'b0;
      chk("bvalid_clr", 32'(s_axi_bvalid), 32'd0);
      chk("awready_back", 32'(s_axi_awready), 32'd1);
      chk("wready_back", 32'(s_axi_wready), 32'd1);
   endtask

   task automatic axi_rd(input logic [7:0] a, input int rdly);
      logic [31:0] ev;
      logic [1:0]  er;
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      chk("arready", 32'(s_axi_arready), 32'd1);
      ev = reg_model(a);
      er = mapped(a) ? 2'b00 : 2'b10;
      tick();
      s_axi_arvalid = 1'b0;
      for (int i = 0; i < rdly; i++) begin
         chk("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
         chk("rdata_hold", s_axi_rdata, ev);
         chk("arready_busy", 32'(s_axi_arready), 32'd0);
         tick();
      end
      s_axi_rready = 1'b1;
      chk("rvalid", 32'(s_axi_rvalid), 32'd1);
      chk($sformatf("rdata@%h", a), s_axi_rdata, ev);
      chk($sformatf("rresp@%h", a), 32'(s_axi_rresp), 32'(er));
      tick();
      s_axi_rready = 1'b0;
      chk("rvalid_clr", 32'(s_axi_rvalid), 32'd0);
      chk("arready_back", 32'(s_axi_arready), 32'd1);
   endtask

   // reset is asserted away from any clock edge so its effect is purely asynchronous
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_tvalid", 32'(out_tvalid), 32'd0);
      chk("rst_out_tdata", 32'(out_tdata), 32'd0);
      chk("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'b111);
      chk("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'b00);
      chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      src_q.delete();
      exp_q.delete();
      coef_m = '0; stats_m = '0;
      clr_stats = 0; coef_wr = 0; st_in_hs = 0; st_out_hs = 0; prev_stall = 0; rand_in = 0;
      rdy_mode = 0;
      in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int limit);
      for (int n = 0; n < limit && (src_q.size() > 0 || exp_q.size() > 0); n++) tick();
      tick();
      tick();
      chk("drain_left", 32'(src_q.size() + exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, last, cnt;
      do_reset();
      axi_rd(8'h00, 0);
      axi_rd(8'h04, 0);
      axi_rd(8'h08, 0);
      axi_rd(8'h0C, 0);

      axi_wr(8'h0C, 32'h0000_0001, 4'b1111, 0, 0);
      src_q = '{16'd0, 16'd1, 16'd2, 16'd99, 16'd100, 16'd65534, 16'd65535};
      rdy_mode = 0;
      first = -1; last = -1; cnt = 0;
      for (int n = 0; n < 40 && (src_q.size() > 0 || exp_q.size() > 0); n++) begin
         tick();
         if (st_out_hs) begin
            if (first < 0) first = n;
            last = n;
            cnt++;
         end
      end
      chk("burst_span", 32'(last - first), 32'd6);
      chk("burst_count", 32'(cnt), 32'd7);
      drain(10);
      axi_rd(8'h08, 1);

      axi_wr(8'h0C, 32'h0000_0010, 4'b0011, 0, 0);
      src_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
      rdy_mode = 1;
      drain(40);
      rdy_mode = 0;

      axi_wr(8'h0C, 32'h0000_1200, 4'b0011, 0, 0);
      axi_wr(8'h0C, 32'hFFFF_FF05, 4'b0001, 2, 3);
      axi_rd(8'h0C, 0);
      axi_wr(8'h0C, 32'h0000_1200, 4'b0011, 0, 0);
      axi_wr(8'h0C, 32'hFFFF_FF05, 4'b0001, -2, 3);
      axi_rd(8'h0C, 2);

      axi_rd(8'h10, 0);
      axi_wr(8'h10, 32'h1234_5678, 4'b1111, 0, 1);
      axi_rd(8'h0C, 0);
      axi_rd(8'h08, 0);

      src_q.push_back(16'h0042);
      tick();
      tick();
      chk("coincide_out_hs", 32'(st_out_hs), 32'd1);
      axi_wr(8'h08, 32'h0, 4'b1111, 0, 0);
      axi_rd(8'h08, 0);

      rdy_mode = 2;
      rand_in  = 1;
      for (int i = 0; i < 30; i++) src_q.push_back(16'($urandom));
      for (int k = 0; k < 8; k++) begin
         logic [7:0] addrs [5];
         addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14};
         if ($urandom_range(0, 1) == 1)
            axi_wr(addrs[$urandom_range(0, 4)] == 8'h04 ? 8'h0C : addrs[$urandom_range(0, 4)],
                   $urandom, 4'($urandom), $urandom_range(0, 4) - 2, $urandom_range(0, 2));
         else
            axi_rd(addrs[$urandom_range(0, 4)], $urandom_range(0, 2));
      end
      drain(400);
      rand_in  = 0;
      rdy_mode = 0;
      axi_rd(8'h08, 0);
      axi_rd(8'h0C, 0);

      axi_wr(8'h0C, 32'h0000_0777, 4'b0011, 0, 0);
      for (int i = 0; i < 5; i++) src_q.push_back(16'(i * 3));
      repeat (3) tick();
      chk("pre_reset_valid", 32'(out_tvalid), 32'd1);
      do_reset();
      axi_rd(8'h0C, 0);
      axi_rd(8'h08, 0);
      chk("post_reset_idle", 32'(out_tvalid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
